nbody_step_scheduler: RTL and testbench

Sequencer for one N-body simulation timestep. On a rising edge of the host-written start bit it clears the acceleration registers, then issues every unordered body pair (i,j) to the pairwise force unit, and then issues each body to the integration unit. It reports completion through a done flag. It sits between the Avalon register file (start bit, body count, done bit) and the force/integration datapaths.

---
 rtl/nbody_step_scheduler.sv | 138 +++++++++++++
 tb/tb_nbody_step_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbody_step_scheduler.sv
// Timestep sequencer: clears accelerations, walks every unordered body pair
// through the force unit, then every body through the integration unit.
module nbody_step_scheduler #(
  parameter int unsigned MAX_BODIES = 10,
  parameter int unsigned IDX_W      = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [31:0]      NUM_BODIES,
  output logic             CLEAR_ACCS,
  output logic             PAIR_VALID,
  input  logic             PAIR_READY,
  output logic [IDX_W-1:0] PAIR_I,
  output logic [IDX_W-1:0] PAIR_J,
  input  logic             FORCE_IDLE,
  output logic             INT_VALID,
  input  logic             INT_READY,
  output logic [IDX_W-1:0] INT_IDX,
  input  logic             INT_IDLE,
  output logic             BUSY,
  output logic             DONE,
  output logic [15:0]      STEP_COUNT
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PAIRS,
    S_DRAIN_F,
    S_INTEG,
    S_DRAIN_I,
    S_DONE
  } state_t;

  state_t           state, next_state;
  logic             start_q;
  logic             rise;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] n_clamped;
  logic [CNT_W-1:0] last;
  logic [IDX_W-1:0] pi, pj, ii;
  logic [15:0]      steps;
  logic             pair_fire, int_fire;
  logic             pj_end, pi_end, ii_end;

  assign rise      = START & ~start_q;
  // Clamp decision uses the full 32-bit count so huge values never alias small ones.
  assign n_clamped = (NUM_BODIES > 32'(MAX_BODIES)) ? CNT_W'(MAX_BODIES)
                                                    : NUM_BODIES[CNT_W-1:0];
  assign last      = count - CNT_W'(1);
  assign pair_fire = PAIR_VALID & PAIR_READY;
  assign int_fire  = INT_VALID & INT_READY;
  assign pj_end    = ({1'b0, pj} == last);
  assign pi_end    = ({1'b0, pi} == (last - CNT_W'(1)));
  assign ii_end    = ({1'b0, ii} == last);

  assign PAIR_I     = pi;
  assign PAIR_J     = pj;
  assign INT_IDX    = ii;
  assign STEP_COUNT = steps;

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    CLEAR_ACCS = 1'b0;
    PAIR_VALID = 1'b0;
    INT_VALID  = 1'b0;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    unique case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (rise) next_state = (n_clamped == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        CLEAR_ACCS = 1'b1;
        next_state = (count >= CNT_W'(2)) ? S_PAIRS : S_INTEG;
      end
      S_PAIRS: begin
        PAIR_VALID = 1'b1;
        if (pair_fire && pj_end && pi_end) next_state = S_DRAIN_F;
      end
      S_DRAIN_F: begin
        if (FORCE_IDLE) next_state = S_INTEG;
      end
      S_INTEG: begin
        INT_VALID = 1'b1;
        if (int_fire && ii_end) next_state = S_DRAIN_I;
      end
      S_DRAIN_I: begin
        if (INT_IDLE) next_state = S_DONE;
      end
      S_DONE: begin
        BUSY = 1'b0;
        DONE = 1'b1;
        if (!START) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_q <= 1'b0;
      count   <= '0;
      pi      <= '0;
      pj      <= '0;
      ii      <= '0;
      steps   <= '0;
    end else begin
      start_q <= START;
      if (state == S_IDLE && rise) count <= n_clamped;
      if (state == S_CLEAR) begin
        pi <= '0;
        pj <= IDX_W'(1);
        ii <= '0;
      end
      if (pair_fire) begin
        if (pj_end) begin
          pi <= pi + IDX_W'(1);
          pj <= pi + IDX_W'(2);
        end else begin
          pj <= pj + IDX_W'(1);
        end
      end
      if (int_fire && !ii_end) ii <= ii + IDX_W'(1);
      if (next_state == S_DONE && state != S_DONE) steps <= steps + 16'd1;
    end
  end

endmodule

// File: tb/tb_nbody_step_scheduler.sv
// Self-checking bench: scoreboard of expected pair/index streams built from
// the step rules, checked every cycle, plus directed timing expectations.
module tb_nbody_step_scheduler;

  localparam int unsigned MAXB = 10;
  localparam int unsigned IW   = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          START;
  logic [31:0]   NUM_BODIES;
  logic          CLEAR_ACCS;
  logic          PAIR_VALID;
  logic          PAIR_READY;
  logic [IW-1:0] PAIR_I;
  logic [IW-1:0] PAIR_J;
  logic          FORCE_IDLE;
  logic          INT_VALID;
  logic          INT_READY;
  logic [IW-1:0] INT_IDX;
  logic          INT_IDLE;
  logic          BUSY;
  logic          DONE;
  logic [15:0]   STEP_COUNT;

  nbody_step_scheduler #(.MAX_BODIES(MAXB), .IDX_W(IW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .NUM_BODIES(NUM_BODIES),
    .CLEAR_ACCS(CLEAR_ACCS), .PAIR_VALID(PAIR_VALID), .PAIR_READY(PAIR_READY),
    .PAIR_I(PAIR_I), .PAIR_J(PAIR_J), .FORCE_IDLE(FORCE_IDLE),
    .INT_VALID(INT_VALID), .INT_READY(INT_READY), .INT_IDX(INT_IDX),
    .INT_IDLE(INT_IDLE), .BUSY(BUSY), .DONE(DONE), .STEP_COUNT(STEP_COUNT)
  );

  always #10 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned mode = 0;
  int unsigned phase = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshake partners: 0 = always ready/idle, 1 = ready pattern 1,0,0,1, 2 = random
  always @(posedge CLK) begin
    #1;
    phase++;
    case (mode)
      1: begin
        PAIR_READY = (phase % 4 == 0) || (phase % 4 == 3);
        INT_READY  = (phase % 4 == 0) || (phase % 4 == 3);
        FORCE_IDLE = 1'b1;
        INT_IDLE   = 1'b1;
      end
      2: begin
        PAIR_READY = 1'($urandom_range(0, 1));
        INT_READY  = 1'($urandom_range(0, 1));
        FORCE_IDLE = ($urandom_range(0, 9) < 6);
        INT_IDLE   = ($urandom_range(0, 9) < 6);
      end
      default: begin
        PAIR_READY = 1'b1;
        INT_READY  = 1'b1;
        FORCE_IDLE = 1'b1;
        INT_IDLE   = 1'b1;
      end
    endcase
  end

  // Reference model state
  logic [7:0]    pq[$];
  logic [IW-1:0] iq[$];
  logic [7:0]    obs_p[$];
  logic [IW-1:0] obs_i[$];
  int unsigned   pcyc[$];
  int unsigned   icyc[$];
  bit            held_p = 0, held_i = 0;
  logic [7:0]    hp;
  logic [IW-1:0] hi;
  logic [15:0]   model_steps = '0;
  bit            prev_done = 0;
  int unsigned   clear_cyc = 32'hFFFF_FFFF;
  int unsigned   trig_cyc = 0;
  int unsigned   done_cyc = 0;

  always @(negedge CLK) begin
    if (RESET) begin
      pq.delete();
      iq.delete();
      model_steps = '0;
      prev_done   = 0;
      held_p      = 0;
      held_i      = 0;
      clear_cyc   = 32'hFFFF_FFFF;
    end else begin
      if (held_p) chk("pair_hold", 32'({PAIR_VALID, PAIR_I, PAIR_J}), 32'({1'b1, hp}));
      if (held_i) chk("int_hold", 32'({INT_VALID, INT_IDX}), 32'({1'b1, hi}));
      held_p = PAIR_VALID && !PAIR_READY;
      hp     = {PAIR_I, PAIR_J};
      held_i = INT_VALID && !INT_READY;
      hi     = INT_IDX;
      if (PAIR_VALID && PAIR_READY) begin
        obs_p.push_back({PAIR_I, PAIR_J});
        pcyc.push_back(cyc);
        if (pq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pair_extra: got (%0d,%0d) expected no pair", PAIR_I, PAIR_J);
        end else chk("pair", 32'({PAIR_I, PAIR_J}), 32'(pq.pop_front()));
      end
      if (INT_VALID && INT_READY) begin
        obs_i.push_back(INT_IDX);
        icyc.push_back(cyc);
        if (iq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL int_extra: got %0d expected no index", INT_IDX);
        end else chk("int_idx", 32'(INT_IDX), 32'(iq.pop_front()));
      end
      chk("clear_accs", 32'(CLEAR_ACCS), 32'(cyc == clear_cyc));
      chk("valid_excl", 32'(PAIR_VALID & INT_VALID), 32'd0);
      chk("busy_done_excl", 32'(BUSY & DONE), 32'd0);
      if (PAIR_VALID || INT_VALID || CLEAR_ACCS) chk("busy_active", 32'(BUSY), 32'd1);
      if (DONE && !prev_done) begin
        model_steps = model_steps + 16'd1;
        done_cyc    = cyc;
        chk("pairs_left_at_done", pq.size(), 32'd0);
        chk("ints_left_at_done", iq.size(), 32'd0);
      end
      prev_done = DONE;
      chk("step_count", 32'(STEP_COUNT), 32'(model_steps));
    end
  end

  task automatic arm(input logic [31:0] nb);
    int unsigned n;
    n = (nb > MAXB) ? MAXB : nb;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned j = i + 1; j < n; j++) pq.push_back({4'(i), 4'(j)});
      iq.push_back(4'(i));
    end
    obs_p.delete();
    obs_i.delete();
    pcyc.delete();
    icyc.delete();
    trig_cyc   = cyc;
    clear_cyc  = (n > 0) ? cyc + 1 : 32'hFFFF_FFFF;
    NUM_BODIES = nb;
    START      = 1'b1;
  endtask

  task automatic wait_done();
    for (int unsigned k = 0; k < 1000; k++) begin
      @(negedge CLK);
      #1;
      if (DONE) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout: DONE=0 after 1000 cycles, expected 1");
  endtask

  task automatic release_start();
    @(posedge CLK);
    #1 START = 1'b0;
    @(negedge CLK);
    chk("done_until_edge", 32'(DONE), 32'd1);
    @(negedge CLK);
    chk("done_falls", 32'({DONE, BUSY}), 32'd0);
  endtask

  initial begin
    #1_600_000;
    $display("FAIL global_timeout: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n, cnt;
    logic [31:0] nb;
    RESET = 1'b1; START = 1'b0; NUM_BODIES = '0;
    PAIR_READY = 1'b1; INT_READY = 1'b1; FORCE_IDLE = 1'b1; INT_IDLE = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("reset_outputs", 32'({CLEAR_ACCS, PAIR_VALID, INT_VALID, BUSY, DONE, PAIR_I, PAIR_J, INT_IDX}), 32'd0);
    chk("reset_steps", 32'(STEP_COUNT), 32'd0);

    // n=3, everything ready: exact cycle timing
    @(posedge CLK); #1 arm(3);
    wait_done();
    chk("n3_pairs", obs_p.size(), 32'd3);
    chk("n3_ints", obs_i.size(), 32'd3);
    if (obs_p.size() == 3 && obs_i.size() == 3) begin
      chk("n3_p0", 32'(obs_p[0]), 32'h01);
      chk("n3_p1", 32'(obs_p[1]), 32'h02);
      chk("n3_p2", 32'(obs_p[2]), 32'h12);
      chk("n3_first_pair_cyc", pcyc[0], trig_cyc + 2);
      chk("n3_last_pair_cyc", pcyc[2], trig_cyc + 4);
      chk("n3_first_int_cyc", icyc[0], trig_cyc + 6);
      chk("n3_last_int_cyc", icyc[2], trig_cyc + 8);
      chk("n3_i2", 32'(obs_i[2]), 32'd2);
    end
    chk("n3_done_cyc", done_cyc, trig_cyc + 10);
    chk("n3_steps", 32'(STEP_COUNT), 32'd1);
    repeat (4) begin
      @(negedge CLK);
      chk("done_held", 32'(DONE), 32'd1);
    end
    release_start();

    // n=4, stalling ready, spurious START edge during PAIRS
    mode = 1;
    @(posedge CLK); #1 arm(4);
    repeat (6) @(posedge CLK);
    #1 START = 1'b0;
    @(posedge CLK);
    #1 START = 1'b1;
    @(negedge CLK);
    chk("n4_still_pairs", 32'(PAIR_VALID), 32'd1);
    wait_done();
    chk("n4_pairs", obs_p.size(), 32'd6);
    if (obs_p.size() == 6) chk("n4_last", 32'(obs_p[5]), 32'h23);
    chk("n4_steps", 32'(STEP_COUNT), 32'd2);
    release_start();

    // n=0: straight to DONE, no clear
    mode = 0;
    @(posedge CLK); #1 arm(0);
    wait_done();
    chk("n0_done_cyc", done_cyc, trig_cyc + 1);
    chk("n0_ints", obs_i.size(), 32'd0);
    release_start();

    // n=1 with START dropped before DONE is entered: one DONE cycle
    @(posedge CLK); #1 arm(1);
    @(posedge CLK); #1 START = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (DONE) cnt++;
    end
    chk("n1_done_cycles", cnt, 32'd1);
    chk("n1_pairs", obs_p.size(), 32'd0);
    chk("n1_ints", obs_i.size(), 32'd1);
    chk("n1_steps", 32'(STEP_COUNT), 32'd4);

    // clamp: 15 -> 10
    @(posedge CLK); #1 arm(15);
    wait_done();
    chk("n15_pairs", obs_p.size(), 32'd45);
    if (obs_p.size() == 45) chk("n15_last", 32'(obs_p[44]), 32'h89);
    chk("n15_ints", obs_i.size(), 32'd10);
    release_start();

    // reset in the middle of PAIRS at pair (1,3)
    @(posedge CLK); #1 arm(5);
    for (int unsigned k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (PAIR_VALID && PAIR_I == 4'd1 && PAIR_J == 4'd3) break;
    end
    #1 RESET = 1'b1; START = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("midreset_outputs", 32'({CLEAR_ACCS, PAIR_VALID, INT_VALID, BUSY, DONE, PAIR_I, PAIR_J, INT_IDX}), 32'd0);
    chk("midreset_steps", 32'(STEP_COUNT), 32'd0);
    @(posedge CLK); #1 arm(5);
    wait_done();
    chk("restart_pairs", obs_p.size(), 32'd10);
    if (obs_p.size() > 0) chk("restart_first", 32'(obs_p[0]), 32'h01);
    chk("restart_steps", 32'(STEP_COUNT), 32'd1);
    release_start();

    // randomized steps against the scoreboard
    mode = 2;
    for (int unsigned it = 0; it < 20; it++) begin
      if (it % 5 == 4) nb = 32'h8000_0000 | 32'($urandom_range(0, 9));
      else             nb = 32'($urandom_range(0, 15));
      n = (nb > MAXB) ? MAXB : nb;
      @(posedge CLK); #1 arm(nb);
      wait_done();
      chk("rnd_pair_count", obs_p.size(), n * (n - 1) / 2);
      chk("rnd_int_count", obs_i.size(), n);
      release_start();
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
